// File: rtl/sub_bytes_engine_if.sv
// Block handshake bundle for the SubBytes engine: producer side (in_*),
// consumer side (out_*) and a busy status flag.
interface sub_bytes_engine_if #(
  parameter int NBYTES = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_inv;
  logic [8*NBYTES-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_data;
  logic                  busy;

  // Side that offers blocks and consumes results
  modport master (
    output in_valid, in_inv, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  // The engine itself
  modport slave (
    input  in_valid, in_inv, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/sub_bytes_engine.sv
// AES SubBytes / InvSubBytes engine. A block of NBYTES bytes is captured
// into a working register and substituted in place, LANES bytes per cycle,
// starting at byte 0. The result stays on out_data until the next block.
module sub_bytes_engine #(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  sub_bytes_engine_if.slave bus
);

  localparam int NSTEPS = NBYTES / LANES;
  localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEPS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Reject lane counts that do not tile the block exactly
  if ((LANES < 1) || (LANES > NBYTES) || ((NBYTES % LANES) != 0)) begin : g_bad_config
    $error("sub_bytes_engine: LANES must lie in 1..NBYTES and divide NBYTES");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Forward S-box, FIPS-197, indexed by input byte
  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Inverse S-box, exact inverse of the table above
  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // One S-box lane; every lane uses this same function with the block-wide mode
  function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic inv);
    return inv ? SBOX_INV[x] : SBOX_FWD[x];
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [8*NBYTES-1:0] work_q, work_d;
  logic                inv_q, inv_d;

  // Next state: accept a block, substitute LANES bytes per step, wait for the consumer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    inv_d   = inv_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_data;
          inv_d   = bus.in_inv;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[(int'(cnt_q) * LANES + l) * 8 +: 8] =
            sub_byte(work_q[(int'(cnt_q) * LANES + l) * 8 +: 8], inv_q);
        end
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, lane counter, working block and latched mode; reset discards any block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
    end
  end

  // Handshake outputs decode the registered state only, so they never follow the inputs
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = work_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine: scoreboard of expected blocks
// built from an independent GF(2^8) S-box model, plus a LANES sweep.
module tb_sub_bytes_engine;

  localparam int NB = 16;

  localparam logic [127:0] VEC_IN  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
  localparam logic [127:0] VEC_OUT = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
  localparam logic [127:0] ALL_63  = {16{8'h63}};
  localparam logic [127:0] ALL_52  = {16{8'h52}};

  logic clk;
  logic rst;

  int checkCount = 0;
  int errCount   = 0;

  logic [7:0]   fwdModel [256];
  logic [7:0]   invModel [256];
  logic [127:0] expQ [$];

  sub_bytes_engine_if #(.NBYTES(NB)) dut_if ();

  sub_bytes_engine #(.NBYTES(NB), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  // Sweep instances share data/mode/ready; each has its own valid
  logic [4:0]   sw_valid;
  logic         sw_inv;
  logic [127:0] sw_data;
  logic         sw_ready;
  logic         sw_out_valid [5];
  logic         sw_in_ready  [5];
  logic         sw_busy      [5];
  logic [127:0] sw_out_data  [5];

  for (genvar g = 0; g < 5; g++) begin : g_sweep
    sub_bytes_engine_if #(.NBYTES(NB)) sif ();
    assign sif.in_valid    = sw_valid[g];
    assign sif.in_inv      = sw_inv;
    assign sif.in_data     = sw_data;
    assign sif.out_ready   = sw_ready;
    assign sw_out_valid[g] = sif.out_valid;
    assign sw_in_ready[g]  = sif.in_ready;
    assign sw_busy[g]      = sif.busy;
    assign sw_out_data[g]  = sif.out_data;
    sub_bytes_engine #(.NBYTES(NB), .LANES(1 << g)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
    );
  end

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // GF(2^8) multiply with the AES polynomial
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Build S-box model from inverse + affine map, inverse table by inversion
  task automatic buildModel();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      fwdModel[x] = s;
      invModel[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] modelBlock(input logic [127:0] data, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < NB; i++) begin
      r[8*i +: 8] = inv ? invModel[data[8*i +: 8]] : fwdModel[data[8*i +: 8]];
    end
    return r;
  endfunction

  // Offer a block, wait for the accepting edge, push its expected result
  task automatic applyStimulus(input logic [127:0] data, input logic inv);
    int waitCycles = 0;
    dut_if.in_valid = 1'b1;
    dut_if.in_data  = data;
    dut_if.in_inv   = inv;
    while (!dut_if.in_ready && waitCycles < 64) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput("in_ready before accept", 128'(dut_if.in_ready), 128'(1));
    @(posedge clk); #1;
    dut_if.in_valid = 1'b0;
    dut_if.in_data  = ~data;
    dut_if.in_inv   = ~inv;
    expQ.push_back(modelBlock(data, inv));
  endtask

  // Wait (bounded) for out_valid, check latency and data against the scoreboard
  task automatic collectResult(input string tag, input int expLat, output logic [127:0] got);
    int lat = 0;
    while (!dut_if.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 128'(lat), 128'(expLat));
    checkOutput({tag, " in_ready in DONE"}, 128'(dut_if.in_ready), 128'(0));
    checkOutput({tag, " busy in DONE"}, 128'(dut_if.busy), 128'(1));
    got = dut_if.out_data;
    if (expQ.size() == 0) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL %s scoreboard: observed %h expected none queued", tag, got);
    end else begin
      checkOutput({tag, " data"}, got, expQ.pop_front());
    end
  endtask

  // Complete the output handshake and check the return to IDLE
  task automatic releaseResult(input string tag, input logic [127:0] held);
    dut_if.out_ready = 1'b1;
    @(posedge clk); #1;
    dut_if.out_ready = 1'b0;
    checkOutput({tag, " out_valid after take"}, 128'(dut_if.out_valid), 128'(0));
    checkOutput({tag, " in_ready after take"}, 128'(dut_if.in_ready), 128'(1));
    checkOutput({tag, " busy after take"}, 128'(dut_if.busy), 128'(0));
    checkOutput({tag, " out_data kept in IDLE"}, dut_if.out_data, held);
  endtask

  // Hard stop if anything hangs
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    logic [127:0] got;
    logic [127:0] fwdRes;
    logic [127:0] data;
    logic         sawValid;
    int           lat;

    dut_if.in_valid  = 1'b0;
    dut_if.in_inv    = 1'b0;
    dut_if.in_data   = '0;
    dut_if.out_ready = 1'b0;
    sw_valid = '0;
    sw_inv   = 1'b0;
    sw_data  = '0;
    sw_ready = 1'b0;
    rst = 1'b0;
    buildModel();
    #2 rst = 1'b1;
    #20;

    checkOutput("reset in_ready", 128'(dut_if.in_ready), 128'(1));
    checkOutput("reset out_valid", 128'(dut_if.out_valid), 128'(0));
    checkOutput("reset busy", 128'(dut_if.busy), 128'(0));
    checkOutput("reset out_data", dut_if.out_data, 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 round-1 forward, accepted on the first edge after reset
    applyStimulus(VEC_IN, 1'b0);
    checkOutput("fips busy after accept", 128'(dut_if.busy), 128'(1));
    collectResult("fips fwd", 4, got);
    checkOutput("fips fwd known answer", got, VEC_OUT);
    releaseResult("fips fwd", got);

    // Inverse of the known answer restores the input
    applyStimulus(VEC_OUT, 1'b1);
    collectResult("fips inv", 4, got);
    checkOutput("fips inv known answer", got, VEC_IN);
    releaseResult("fips inv", got);

    // All-zero blocks in both modes
    applyStimulus('0, 1'b0);
    collectResult("zero fwd", 4, got);
    checkOutput("zero fwd all 63", got, ALL_63);
    releaseResult("zero fwd", got);
    applyStimulus('0, 1'b1);
    collectResult("zero inv", 4, got);
    checkOutput("zero inv all 52", got, ALL_52);
    releaseResult("zero inv", got);

    // Every byte value forward, then back through the inverse
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < NB; i++) data[8*i +: 8] = 8'(16 * k + i);
      applyStimulus(data, 1'b0);
      collectResult($sformatf("exh fwd %0d", k), 4, fwdRes);
      releaseResult($sformatf("exh fwd %0d", k), fwdRes);
      applyStimulus(fwdRes, 1'b1);
      collectResult($sformatf("exh inv %0d", k), 4, got);
      checkOutput($sformatf("exh roundtrip %0d", k), got, data);
      releaseResult($sformatf("exh inv %0d", k), got);
    end

    // Backpressure: hold the result 10 cycles while a new block is offered
    data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(data, 1'b0);
    collectResult("bp", 4, got);
    dut_if.in_valid = 1'b1;
    dut_if.in_data  = ~data;
    dut_if.in_inv   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp hold data %0d", c), dut_if.out_data, got);
      checkOutput($sformatf("bp hold valid %0d", c), 128'(dut_if.out_valid), 128'(1));
      checkOutput($sformatf("bp hold in_ready %0d", c), 128'(dut_if.in_ready), 128'(0));
    end
    dut_if.in_valid = 1'b0;
    releaseResult("bp", got);

    // Reset pulsed at cnt=2 discards the block
    data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(data, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst out_valid", 128'(dut_if.out_valid), 128'(0));
    checkOutput("midrst busy", 128'(dut_if.busy), 128'(0));
    checkOutput("midrst in_ready", 128'(dut_if.in_ready), 128'(1));
    checkOutput("midrst out_data", dut_if.out_data, 128'(0));
    void'(expQ.pop_front());
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (dut_if.out_valid) sawValid = 1'b1;
    end
    checkOutput("midrst no stray out_valid", 128'(sawValid), 128'(0));
    checkOutput("midrst out_data after release", dut_if.out_data, 128'(0));
    data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(data, 1'b1);
    collectResult("post rst", 4, got);
    releaseResult("post rst", got);

    // LANES sweep: same block, latency NBYTES/LANES
    sw_data = VEC_IN;
    sw_inv  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("sweep%0d in_ready", k), 128'(sw_in_ready[k]), 128'(1));
      sw_valid[k] = 1'b1;
      @(posedge clk); #1;
      sw_valid[k] = 1'b0;
      expQ.push_back(modelBlock(VEC_IN, 1'b0));
      checkOutput($sformatf("sweep%0d busy", k), 128'(sw_busy[k]), 128'(1));
      lat = 0;
      while (!sw_out_valid[k] && lat < 64) begin
        @(posedge clk); #1;
        lat++;
      end
      checkOutput($sformatf("sweep%0d latency", k), 128'(lat), 128'(16 >> k));
      checkOutput($sformatf("sweep%0d data", k), sw_out_data[k], expQ.pop_front());
      checkOutput($sformatf("sweep%0d known answer", k), sw_out_data[k], VEC_OUT);
      sw_ready = 1'b1;
      @(posedge clk); #1;
      sw_ready = 1'b0;
      checkOutput($sformatf("sweep%0d out_valid after take", k), 128'(sw_out_valid[k]), 128'(0));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
